// File: rtl/spiker_reader.sv
// rtl/spiker_reader.sv - per-channel spike rising-edge detector with windowed OR readout
// One flag per channel is published each window: set if that channel rose at least once in it.
module spiker_reader #(
  parameter int N_SPIKES = 784,
  parameter int WINDOW   = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [N_SPIKES-1:0] data_in,
  output logic [N_SPIKES-1:0] data_out
);

  localparam int CNT_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [N_SPIKES-1:0] in_q, in_d;
  logic [N_SPIKES-1:0] prev_q, prev_d;
  logic [N_SPIKES-1:0] acc_q, acc_d;
  logic [N_SPIKES-1:0] out_q, out_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [N_SPIKES-1:0] ev;
  logic                close_win;

  always_comb begin
    in_d      = data_in;
    prev_d    = in_q;
    ev        = in_q & ~prev_q;
    close_win = (cnt_q == CNT_LAST);
    out_d     = out_q;
    acc_d     = acc_q | ev;
    cnt_d     = cnt_q + CNT_ONE;
    // An event landing on the close edge belongs to the window being closed.
    if (close_win) begin
      out_d = acc_q | ev;
      acc_d = '0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      in_q   <= '0;
      prev_q <= '0;
      acc_q  <= '0;
      out_q  <= '0;
      cnt_q  <= '0;
    end else begin
      in_q   <= in_d;
      prev_q <= prev_d;
      acc_q  <= acc_d;
      out_q  <= out_d;
      cnt_q  <= cnt_d;
    end
  end

  assign data_out = out_q;

endmodule

// File: tb/tb_spiker_reader.sv
// tb/tb_spiker_reader.sv - randomized and directed bench for spiker_reader
// Three instances (8ch/W4, 8ch/W1, 784ch/W16) share reset and stimulus.
module tb_spiker_reader;

  localparam int NW = 784;

  logic          clk = 1'b0;
  logic          rst;
  logic [NW-1:0] din;
  logic [7:0]    out_a;
  logic [7:0]    out_b;
  logic [NW-1:0] out_c;

  int n_checks = 0;
  int n_errors = 0;

  // model state: samples of data_in indexed by edge number since release
  logic [NW-1:0] s_hist[$];
  int            edge_n;
  logic [NW-1:0] exp_a, exp_b, exp_c;

  always #5 clk = ~clk;

  spiker_reader #(.N_SPIKES(8), .WINDOW(4)) dut_a (
    .clk_i(clk), .rst_i(rst), .data_in(din[7:0]), .data_out(out_a)
  );
  spiker_reader #(.N_SPIKES(8), .WINDOW(1)) dut_b (
    .clk_i(clk), .rst_i(rst), .data_in(din[7:0]), .data_out(out_b)
  );
  spiker_reader #(.N_SPIKES(NW), .WINDOW(16)) dut_c (
    .clk_i(clk), .rst_i(rst), .data_in(din), .data_out(out_c)
  );

  task automatic check_eq(input string tag, input logic [NW-1:0] got, input logic [NW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [NW-1:0] samp(input int j);
    if (j < 1) return '0;
    return s_hist[j-1];
  endfunction

  // Flags for the window closing at edge m: any channel that was 0 then 1 in
  // consecutive samples, where the rise is seen one edge after it is sampled.
  function automatic logic [NW-1:0] window_or(input int m, input int w);
    logic [NW-1:0] acc;
    acc = '0;
    for (int k = m - w + 1; k <= m; k++)
      acc |= samp(k-1) & ~samp(k-2);
    return acc;
  endfunction

  task automatic model_update(input logic r, input logic [NW-1:0] d);
    if (r) begin
      edge_n = 0;
      s_hist.delete();
      exp_a = '0;
      exp_b = '0;
      exp_c = '0;
    end else begin
      edge_n++;
      s_hist.push_back(d);
      if (edge_n % 4 == 0)  exp_a = window_or(edge_n, 4);
      exp_b = window_or(edge_n, 1);
      if (edge_n % 16 == 0) exp_c = window_or(edge_n, 16);
    end
  endtask

  task automatic tick(input logic r, input logic [NW-1:0] d);
    rst = r;
    din = d;
    @(posedge clk);
    model_update(r, d);
    #1;
    check_eq("model_a", {776'd0, out_a}, {776'd0, exp_a[7:0]});
    check_eq("model_b", {776'd0, out_b}, {776'd0, exp_b[7:0]});
    check_eq("model_c", out_c, exp_c);
  endtask

  task automatic do_reset(input logic [NW-1:0] d);
    tick(1'b1, d);
  endtask

  logic [NW-1:0] alt;
  logic [NW-1:0] cur;
  logic [799:0]  flip;
  logic [4:0]    pat_b;

  initial begin
    rst = 1'b1;
    din = '0;
    edge_n = 0;
    exp_a = '0; exp_b = '0; exp_c = '0;
    alt = {392{2'b10}};

    // reset holds outputs at zero even with all inputs high
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, {NW{1'b1}});
      check_eq("rst_a", {776'd0, out_a}, '0);
      check_eq("rst_c", out_c, '0);
    end

    // single held spike: one flag in window 1 only
    do_reset('0);
    for (int e = 1; e <= 8; e++) begin
      tick(1'b0, 784'h01);
      if (e <= 3) check_eq("single_early", {776'd0, out_a}, '0);
      if (e == 4) check_eq("single_e4", {776'd0, out_a}, 784'h01);
      if (e == 8) check_eq("single_e8", {776'd0, out_a}, 784'h00);
    end

    // two pulses on bit 2 collapse; bit 7 rising on the close edge is captured
    do_reset('0);
    for (int e = 1; e <= 4; e++) tick(1'b0, '0);
    tick(1'b0, 784'h04);
    tick(1'b0, 784'h00);
    tick(1'b0, 784'h84);
    tick(1'b0, 784'h80);
    check_eq("or_collapse_e8", {776'd0, out_a}, 784'h84);

    // window of one: bit 3 = 0,1,1,0,1 gives flags 0,1,0,0,1 after edges 2..6
    do_reset('0);
    pat_b = 5'b10010;
    for (int e = 1; e <= 7; e++) begin
      tick(1'b0, (e == 2 || e == 3 || e == 5) ? 784'h08 : 784'h00);
      if (e >= 2 && e <= 6)
        check_eq("w1_bit3", {783'd0, out_b[3]}, {783'd0, pat_b[e-2]});
    end

    // reset mid-window drops the pending event
    do_reset('0);
    for (int e = 1; e <= 3; e++) tick(1'b0, '0);
    tick(1'b0, 784'h10);
    tick(1'b0, 784'h10);
    do_reset('0);
    check_eq("midrst_clear", {776'd0, out_a}, '0);
    for (int e = 1; e <= 8; e++) begin
      tick(1'b0, '0);
      if (e == 4 || e == 8) check_eq("midrst_nopub", {776'd0, out_a}, '0);
    end

    // full width alternating patterns
    do_reset('0);
    for (int e = 1; e <= 16; e++) tick(1'b0, alt);
    check_eq("full_odd", out_c, alt);
    for (int e = 17; e <= 32; e++) tick(1'b0, ~alt);
    check_eq("full_even", out_c, ~alt);

    // random sparse toggling with occasional resets
    do_reset('0);
    cur = '0;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < 25; i++)
        flip[i*32 +: 32] = $urandom & $urandom & $urandom;
      cur = cur ^ flip[NW-1:0];
      tick(($urandom_range(0, 149) == 0) ? 1'b1 : 1'b0, cur);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
